shift_sequencer: RTL and testbench

//   Iterative shift engine in front of the ALU writeback/flag path.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 106 ++++++++++
 tb/tb_shift_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the iterative shift engine.
// The engine connects through the slave modport and the requester/consumer through the master modport.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OFFW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [OFFW-1:0]  in_offset;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_offset, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_neg, busy
    );

    modport master (
        output in_valid, in_data, in_offset, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_neg, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative shift engine: accepts one request, shifts one bit per clock,
// then holds a registered result with carry/zero/negative flags until consumed.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int OFFW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Shifting more than WIDTH+1 times cannot change data or carry any further.
    localparam logic [OFFW-1:0] MAX_COUNT = OFFW'(WIDTH + 1);

    localparam logic [1:0] OP_RLS = 2'b10;
    localparam logic [1:0] OP_RAS = 2'b11;

    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic [1:0]       op;
    logic [OFFW-1:0]  count;
    logic             carry;

    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_neg;

    logic [WIDTH-1:0] step_data;
    logic             step_carry;
    logic             accept;

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = res_data;
    assign bus.out_carry = res_carry;
    assign bus.out_zero  = res_zero;
    assign bus.out_neg   = res_neg;

    // Single-bit shift step selected by the latched op (LAS behaves as LLS).
    always_comb begin
        step_data  = {data[WIDTH-2:0], 1'b0};
        step_carry = data[WIDTH-1];
        if (op == OP_RLS) begin
            step_data  = {1'b0, data[WIDTH-1:1]};
            step_carry = data[0];
        end else if (op == OP_RAS) begin
            step_data  = {data[WIDTH-1], data[WIDTH-1:1]};
            step_carry = data[0];
        end
    end

    // Sequencer: latch request, step once per clock, then publish and hold the result.
    // Every request passes through SHIFT, including a zero offset, so the result
    // always appears min(offset, WIDTH+1)+1 clocks after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data      <= '0;
            op        <= '0;
            count     <= '0;
            carry     <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        data  <= bus.in_data;
                        op    <= bus.in_op;
                        count <= (bus.in_offset > MAX_COUNT) ? MAX_COUNT : bus.in_offset;
                        carry <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        data  <= step_data;
                        carry <= step_carry;
                        count <= count - 1'b1;
                    end else begin
                        res_data  <= data;
                        res_carry <= carry;
                        res_zero  <= (data == '0);
                        res_neg   <= data[WIDTH-1];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus backpressure and reset-abort sequences.
module tb_shift_sequencer;
    localparam logic [1:0] LLS = 2'b00;
    localparam logic [1:0] LAS = 2'b01;
    localparam logic [1:0] RLS = 2'b10;
    localparam logic [1:0] RAS = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [3:0] off;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_zero;
        logic       exp_neg;
        int         lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[10];
    vec_t v;

    shift_sequencer_if #(.WIDTH(8), .OFFW(4)) bus ();

    shift_sequencer #(.WIDTH(8), .OFFW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " busy"},      32'(bus.busy),      32'd0);
        check({tag, " out_data"},  32'(bus.out_data),  32'd0);
        check({tag, " flags"},     32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'd0);
    endtask

    // Issue a request, measure latency, check the result, then complete the handshake.
    task automatic run_op(input vec_t t, input string tag);
        int lat;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " in_ready before request"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_op     = t.op;
        bus.in_data   = t.data;
        bus.in_offset = t.off;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'hA5;
        bus.in_offset = 4'hF;
        check({tag, " busy after accept"}, 32'({bus.busy, bus.in_ready}), 32'b10);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) lat = k;
        end
        check({tag, " latency"}, 32'(lat), 32'(t.lat));
        check({tag, " out_data"}, 32'(bus.out_data), 32'(t.exp_data));
        check({tag, " carry/zero/neg"}, 32'({bus.out_carry, bus.out_zero, bus.out_neg}),
              32'({t.exp_carry, t.exp_zero, t.exp_neg}));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " back to idle"}, 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //         op   data   off  exp    c     z     n     lat
        vecs[0] = '{LLS, 8'h05, 4'd3,  8'h28, 1'b0, 1'b0, 1'b0, 4};
        vecs[1] = '{LLS, 8'h81, 4'd1,  8'h02, 1'b1, 1'b0, 1'b0, 2};
        vecs[2] = '{LLS, 8'h81, 4'd0,  8'h81, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{RAS, 8'h90, 4'd2,  8'hE4, 1'b0, 1'b0, 1'b1, 3};
        vecs[4] = '{RAS, 8'h80, 4'd15, 8'hFF, 1'b1, 1'b0, 1'b1, 10};
        vecs[5] = '{RLS, 8'h80, 4'd8,  8'h00, 1'b1, 1'b1, 1'b0, 9};
        vecs[6] = '{RLS, 8'h80, 4'd12, 8'h00, 1'b0, 1'b1, 1'b0, 10};
        vecs[7] = '{LAS, 8'h81, 4'd1,  8'h02, 1'b1, 1'b0, 1'b0, 2};
        vecs[8] = '{RAS, 8'h7F, 4'd9,  8'h00, 1'b0, 1'b1, 1'b0, 10};
        vecs[9] = '{LLS, 8'hFF, 4'd8,  8'h00, 1'b1, 1'b1, 1'b0, 9};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_offset = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 clocks while a competing request is offered.
        v = '{LLS, 8'h05, 4'd3, 8'h28, 1'b0, 1'b0, 1'b0, 4};
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = v.op;
        bus.in_data   = v.data;
        bus.in_offset = v.off;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        begin
            int lat;
            lat = 0;
            for (int k = 1; k <= 20 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) lat = k;
            end
            check("bp latency", 32'(lat), 32'd4);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_op     = RLS;
            bus.in_data   = 8'hF0;
            bus.in_offset = 4'd4;
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d valid/ready", i), 32'({bus.out_valid, bus.in_ready}), 32'b10);
            check($sformatf("bp hold%0d result", i),
                  32'({bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg}), 32'({8'h28, 3'b000}));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        bus.out_ready = 1'b0;
        run_op('{RLS, 8'hF0, 4'd4, 8'h0F, 1'b0, 1'b0, 1'b0, 5}, "bp next");

        // Reset during SHIFT aborts the operation with no result pulse.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = LLS;
        bus.in_data   = 8'h05;
        bus.in_offset = 4'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort busy before reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid || bus.busy) seen = 1'b1;
            end
            check("abort no result", 32'(seen), 32'd0);
        end
        run_op(vecs[3], "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
